eth_tx_mac_sf: RTL and testbench

- Parametrised store-and-forward GMII transmit MAC for 10/100/1000 links; successor to the TX half of the tri-speed MAC.
- Buffers a whole frame from the upper stack, then serialises it on GMII at the link rate: preamble/SFD, payload, zero padding, FCS and IFG.
- Adds configurable preamble, IFG and minimum/maximum frame size, upper-layer abort (drop), oversize rejection and per-event counters.
- Single clock domain (GMII TX clock).

---
 rtl/eth_tx_mac_sf_pkg.sv | 33 +++
 rtl/eth_tx_mac_sf_strobe.sv | 41 ++++
 rtl/eth_tx_mac_sf.sv | 237 +++++++++++++++++++++++
 tb/tb_eth_tx_mac_sf.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_mac_sf_pkg.sv
// Shared Ethernet definitions for the transmit MAC: link speed encoding,
// framing constants and the byte-wise CRC32 used for the FCS.
package eth_tx_mac_sf_pkg;

    typedef enum logic [1:0] {
        LSPEED_10   = 2'b00,
        LSPEED_100  = 2'b01,
        LSPEED_1000 = 2'b10
    } lspeed_t;

    localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;
    localparam int         ETH_MIN_FRAME     = 64;
    localparam int         ETH_MAX_FRAME     = 1518;

    // Reflected CRC32 update, one byte, LSB first as it goes on the wire.
    function automatic logic [31:0] crc32_eth_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Final FCS rearranged so that bits [31:24] are the first byte on the wire.
    function automatic logic [31:0] crc32_eth_flipped(input logic [31:0] crc);
        logic [31:0] f;
        f = ~crc;
        return {f[7:0], f[15:8], f[23:16], f[31:24]};
    endfunction

endpackage

// File: rtl/eth_tx_mac_sf_strobe.sv
// Byte-time strobe generator: one-cycle pulse every 1, 10 or 100 clocks
// depending on link speed.
module eth_byte_strobe
    import eth_tx_mac_sf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] link_speed,
    output logic       strobe
);

    logic [6:0] cnt_reg;
    logic [6:0] limit;
    logic       strobe_reg;

    always_comb begin
        limit = 7'd0;
        case (link_speed)
            LSPEED_10:  limit = 7'd99;
            LSPEED_100: limit = 7'd9;
            default:    limit = 7'd0;
        endcase
    end

    // >= rather than == so a speed change to a shorter period cannot overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            strobe_reg <= 1'b0;
        end else if (cnt_reg >= limit) begin
            cnt_reg    <= '0;
            strobe_reg <= 1'b1;
        end else begin
            cnt_reg    <= cnt_reg + 7'd1;
            strobe_reg <= 1'b0;
        end
    end

    assign strobe = strobe_reg;

endmodule

// File: rtl/eth_tx_mac_sf.sv
// Store-and-forward GMII transmit MAC: buffers one frame, then sends
// preamble/SFD, payload, zero padding, FCS and inter-frame gap at link rate.
module eth_tx_mac_sf
    import eth_tx_mac_sf_pkg::*;
#(
    parameter int MAX_FRAME    = ETH_MAX_FRAME,
    parameter int MIN_FRAME    = ETH_MIN_FRAME,
    parameter int PREAMBLE_LEN = 8,
    parameter int IFG_LEN      = 12,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           link_speed,
    input  logic                 tx_start,
    input  logic                 tx_data_valid,
    input  logic [7:0]           tx_data,
    input  logic                 tx_commit,
    input  logic                 tx_drop,
    output logic                 tx_ready,
    output logic                 gmii_dvalid,
    output logic                 gmii_en,
    output logic                 gmii_er,
    output logic [7:0]           gmii_data,
    output logic [CNT_WIDTH-1:0] perf_tx_frames,
    output logic [CNT_WIDTH-1:0] perf_tx_dropped,
    output logic [CNT_WIDTH-1:0] perf_tx_oversize
);

    localparam int AW = $clog2(MAX_FRAME);
    localparam int CW = $clog2(MAX_FRAME + 2);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_FRAME);
    localparam logic [CW-1:0] OVF_C   = CW'(MAX_FRAME + 1);
    localparam logic [CW-1:0] PAD_C   = CW'(MIN_FRAME - 4);
    localparam logic [7:0]    PLAST_C = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]    PLEN_C  = 8'(PREAMBLE_LEN);
    localparam logic [7:0]    IFG_C   = 8'(IFG_LEN);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PREAMBLE, ST_DATA, ST_PAD, ST_FCS, ST_IFG
    } tx_state_t;

    tx_state_t      state_reg;
    logic [7:0]     cnt_reg;
    logic [CW-1:0]  sent_reg;
    logic [CW-1:0]  frame_len_reg;
    logic [CW-1:0]  wr_count_reg;
    logic [AW-1:0]  rd_addr_reg;
    logic [AW-1:0]  rd_addr_next;
    logic [7:0]     rd_data_reg;
    logic [31:0]    crc_reg;
    logic [31:0]    fcs_sr_reg;
    logic           pending_reg;
    logic           tx_ready_reg;
    logic [1:0]     speed_reg;
    logic           gmii_dvalid_reg;
    logic           gmii_en_reg;
    logic [7:0]     gmii_data_reg;
    logic [CNT_WIDTH-1:0] frames_reg;
    logic [CNT_WIDTH-1:0] dropped_reg;
    logic [CNT_WIDTH-1:0] oversize_reg;

    logic [7:0]     mem [MAX_FRAME];

    logic           strobe;
    logic [CW-1:0]  wr_base;
    logic [CW-1:0]  wr_count_next;
    logic           mem_we;
    logic           pay_has_data;
    logic           pay_has_pad;
    logic [7:0]     pay_byte;
    logic [31:0]    crc_upd;
    logic [31:0]    fcs_word;
    logic           emit_pay;
    logic           advance;

    eth_byte_strobe u_strobe (
        .clk        (clk),
        .reset      (reset),
        .link_speed (speed_reg),
        .strobe     (strobe)
    );

    always_comb begin
        wr_base       = tx_start ? '0 : wr_count_reg;
        mem_we        = tx_ready_reg && tx_data_valid && (wr_base < MAX_C);
        wr_count_next = wr_base;
        if (tx_data_valid && (wr_base != OVF_C))
            wr_count_next = wr_base + CW'(1);
    end

    // Payload byte source: buffered data first, then zero padding, then FCS.
    always_comb begin
        pay_has_data = (sent_reg < frame_len_reg);
        pay_has_pad  = (sent_reg < PAD_C);
        pay_byte     = pay_has_data ? rd_data_reg : 8'h00;
        crc_upd      = crc32_eth_byte(crc_reg, pay_byte);
        fcs_word     = crc32_eth_flipped(crc_reg);
        emit_pay     = strobe && (((state_reg == ST_PREAMBLE) && (cnt_reg == PLEN_C)) ||
                                  (state_reg == ST_DATA) || (state_reg == ST_PAD));
        advance      = emit_pay && pay_has_data;
        rd_addr_next = rd_addr_reg;
        if (state_reg == ST_IDLE)
            rd_addr_next = '0;
        else if (advance)
            rd_addr_next = rd_addr_reg + AW'(1);
    end

    // Read uses the next address so the following byte is ready by the next strobe.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_base[AW-1:0]] <= tx_data;
        rd_data_reg <= mem[rd_addr_next];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            sent_reg        <= '0;
            frame_len_reg   <= '0;
            wr_count_reg    <= '0;
            rd_addr_reg     <= '0;
            crc_reg         <= '1;
            fcs_sr_reg      <= '0;
            pending_reg     <= 1'b0;
            tx_ready_reg    <= 1'b1;
            speed_reg       <= LSPEED_1000;
            gmii_dvalid_reg <= 1'b0;
            gmii_en_reg     <= 1'b0;
            gmii_data_reg   <= '0;
            frames_reg      <= '0;
            dropped_reg     <= '0;
            oversize_reg    <= '0;
        end else begin
            gmii_dvalid_reg <= strobe;
            rd_addr_reg     <= rd_addr_next;
            if (state_reg == ST_IDLE)
                speed_reg <= link_speed;

            if (tx_ready_reg) begin
                wr_count_reg <= wr_count_next;
                if (tx_drop) begin
                    dropped_reg  <= dropped_reg + 1'b1;
                    wr_count_reg <= '0;
                end else if (tx_commit) begin
                    wr_count_reg <= '0;
                    if (wr_count_next > MAX_C) begin
                        oversize_reg <= oversize_reg + 1'b1;
                    end else begin
                        pending_reg   <= 1'b1;
                        frame_len_reg <= wr_count_next;
                        tx_ready_reg  <= 1'b0;
                    end
                end
            end

            if (strobe) begin
                case (state_reg)
                    ST_IDLE: begin
                        gmii_en_reg   <= 1'b0;
                        gmii_data_reg <= 8'h00;
                        if (pending_reg) begin
                            pending_reg   <= 1'b0;
                            state_reg     <= ST_PREAMBLE;
                            cnt_reg       <= 8'd1;
                            sent_reg      <= '0;
                            crc_reg       <= '1;
                            gmii_en_reg   <= 1'b1;
                            gmii_data_reg <= ETH_PREAMBLE_BYTE;
                        end
                    end
                    ST_PREAMBLE: begin
                        if (cnt_reg < PLAST_C) begin
                            gmii_data_reg <= ETH_PREAMBLE_BYTE;
                            cnt_reg       <= cnt_reg + 8'd1;
                        end else if (cnt_reg == PLAST_C) begin
                            gmii_data_reg <= ETH_SFD_BYTE;
                            cnt_reg       <= cnt_reg + 8'd1;
                        end
                    end
                    ST_FCS: begin
                        if (cnt_reg < 8'd4) begin
                            gmii_data_reg <= fcs_sr_reg[31:24];
                            fcs_sr_reg    <= {fcs_sr_reg[23:0], 8'h00};
                            cnt_reg       <= cnt_reg + 8'd1;
                        end else begin
                            gmii_en_reg   <= 1'b0;
                            gmii_data_reg <= 8'h00;
                            state_reg     <= ST_IFG;
                            cnt_reg       <= 8'd1;
                            frames_reg    <= frames_reg + 1'b1;
                        end
                    end
                    ST_IFG: begin
                        if (cnt_reg < IFG_C) begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end else begin
                            state_reg    <= ST_IDLE;
                            tx_ready_reg <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (emit_pay) begin
                if (pay_has_data) begin
                    gmii_data_reg <= rd_data_reg;
                    crc_reg       <= crc_upd;
                    sent_reg      <= sent_reg + CW'(1);
                    state_reg     <= ST_DATA;
                end else if (pay_has_pad) begin
                    gmii_data_reg <= 8'h00;
                    crc_reg       <= crc_upd;
                    sent_reg      <= sent_reg + CW'(1);
                    state_reg     <= ST_PAD;
                end else begin
                    gmii_data_reg <= fcs_word[31:24];
                    fcs_sr_reg    <= {fcs_word[23:0], 8'h00};
                    state_reg     <= ST_FCS;
                    cnt_reg       <= 8'd1;
                end
            end
        end
    end

    assign tx_ready         = tx_ready_reg;
    assign gmii_dvalid      = gmii_dvalid_reg;
    assign gmii_en          = gmii_en_reg;
    assign gmii_er          = 1'b0;
    assign gmii_data        = gmii_data_reg;
    assign perf_tx_frames   = frames_reg;
    assign perf_tx_dropped  = dropped_reg;
    assign perf_tx_oversize = oversize_reg;

endmodule

// File: tb/tb_eth_tx_mac_sf.sv
// Directed bench for eth_tx_mac_sf: frames at all three speeds, padding,
// oversize, drop and mid-frame reset, checked against a bit-serial CRC model.
module tb_eth_tx_mac_sf;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  link_speed;
    logic        tx_start, tx_data_valid, tx_commit, tx_drop;
    logic [7:0]  tx_data;
    logic        tx_ready, gmii_dvalid, gmii_en, gmii_er;
    logic [7:0]  gmii_data;
    logic [31:0] perf_tx_frames, perf_tx_dropped, perf_tx_oversize;

    eth_tx_mac_sf dut (
        .clk              (clk),
        .reset            (reset),
        .link_speed       (link_speed),
        .tx_start         (tx_start),
        .tx_data_valid    (tx_data_valid),
        .tx_data          (tx_data),
        .tx_commit        (tx_commit),
        .tx_drop          (tx_drop),
        .tx_ready         (tx_ready),
        .gmii_dvalid      (gmii_dvalid),
        .gmii_en          (gmii_en),
        .gmii_er          (gmii_er),
        .gmii_data        (gmii_data),
        .perf_tx_frames   (perf_tx_frames),
        .perf_tx_dropped  (perf_tx_dropped),
        .perf_tx_oversize (perf_tx_oversize)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] cap[$];
    int         cap_cyc[$];
    always @(negedge clk) begin
        if (gmii_dvalid === 1'b1) begin
            cap.push_back({gmii_en, gmii_data});
            cap_cyc.push_back(cyc);
        end
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_data[$];
    int mark;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // MSB-first CRC32 over data plus padding; returns FCS bytes in wire order.
    function automatic logic [31:0] ref_fcs(input int n, input int plen);
        logic [31:0] c;
        logic [31:0] f;
        logic [31:0] w;
        logic [7:0]  b;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < plen; k++) begin
            b = (k < n) ? exp_data[k] : 8'h00;
            for (int i = 0; i < 8; i++) begin
                fb = c[31] ^ b[i];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        f = ~c;
        w = '0;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 8; i++)
                w[24 - 8*j + i] = f[31 - 8*j - i];
        return w;
    endfunction

    task automatic fill(input int n, input int a, input int b);
        exp_data.delete();
        for (int i = 0; i < n; i++) exp_data.push_back(8'(a + b * i));
    endtask

    task automatic send();
        @(posedge clk); #1;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        for (int i = 0; i < exp_data.size(); i++) begin
            tx_data       = exp_data[i];
            tx_data_valid = 1'b1;
            @(posedge clk); #1;
        end
        tx_data_valid = 1'b0;
        mark          = cap.size();
        tx_commit     = 1'b1;
        @(posedge clk); #1;
        tx_commit     = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20000 && tx_ready !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        check({tag, "_ready"}, 32'(tx_ready), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int period);
        int n, plen, explen, f, run, nbad, idle, total, pbad;
        logic [31:0] fcs_exp, fcs_got;
        logic [7:0]  eb;
        n       = exp_data.size();
        plen    = (n < 60) ? 60 : n;
        explen  = 8 + plen + 4;
        fcs_exp = ref_fcs(n, plen);
        f = -1;
        for (int i = mark; i < cap.size(); i++)
            if (cap[i][8]) begin f = i; break; end
        check({tag, "_found"}, 32'(f >= 0), 32'd1);
        if (f < 0) return;
        check({tag, "_latency"}, 32'((f - mark) <= 2), 32'd1);
        run = 0;
        while (f + run < cap.size() && cap[f + run][8]) run++;
        check({tag, "_len"}, run, explen);
        nbad = 0;
        for (int k = 0; k < run && k < explen; k++) begin
            if (k < 7)                eb = 8'h55;
            else if (k == 7)          eb = 8'hD5;
            else if (k < 8 + n)       eb = exp_data[k - 8];
            else if (k < 8 + plen)    eb = 8'h00;
            else                      eb = fcs_exp[31 - 8*(k - 8 - plen) -: 8];
            if (cap[f + k][7:0] !== eb) nbad++;
        end
        check({tag, "_bytes"}, nbad, 0);
        fcs_got = '0;
        if (run >= explen)
            for (int j = 0; j < 4; j++) fcs_got[31 - 8*j -: 8] = cap[f + 8 + plen + j][7:0];
        check({tag, "_fcs"}, fcs_got, fcs_exp);
        idle = 0;
        for (int j = 0; j < 12; j++)
            if (f + run + j < cap.size() && !cap[f + run + j][8]) idle++;
        check({tag, "_ifg"}, idle, 12);
        total = 0;
        for (int i = mark; i < cap.size(); i++) if (cap[i][8]) total++;
        check({tag, "_total"}, total, explen);
        pbad = 0;
        for (int j = f; j < f + run - 1; j++)
            if (cap_cyc[j + 1] - cap_cyc[j] != period) pbad++;
        check({tag, "_period"}, pbad, 0);
        $display("frame %s len=%0d strobes=%0d fcs=%08h", tag, n, run, fcs_got);
    endtask

    initial begin
        int mark0, cnt;
        reset = 1'b1; link_speed = 2'b10;
        tx_start = 1'b0; tx_data_valid = 1'b0; tx_data = 8'h00;
        tx_commit = 1'b0; tx_drop = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_en", 32'(gmii_en), 32'd0);
        check("rst_data", 32'(gmii_data), 32'd0);
        check("rst_dvalid", 32'(gmii_dvalid), 32'd0);
        check("rst_frames", perf_tx_frames, 32'd0);
        check("rst_dropped", perf_tx_dropped, 32'd0);
        check("rst_oversize", perf_tx_oversize, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);

        fill(100, 0, 1); send(); wait_ready("g100");
        check_frame("g100", 1);
        check("g100_frames", perf_tx_frames, 32'd1);

        fill(10, 8'hA0, 1); send(); wait_ready("g10");
        check_frame("g10", 1);
        check("g10_frames", perf_tx_frames, 32'd2);

        link_speed = 2'b01;
        fill(64, 1, 3); send(); wait_ready("m100");
        check_frame("m100", 10);
        check("m100_frames", perf_tx_frames, 32'd3);

        link_speed = 2'b00;
        fill(64, 1, 3); send(); wait_ready("m10");
        check_frame("m10", 100);
        check("m10_frames", perf_tx_frames, 32'd4);

        link_speed = 2'b10;
        repeat (200) @(posedge clk);
        fill(1519, 7, 5); send();
        repeat (40) @(negedge clk);
        cnt = 0;
        for (int i = mark; i < cap.size(); i++) if (cap[i][8]) cnt++;
        check("ovs_en", cnt, 0);
        check("ovs_count", perf_tx_oversize, 32'd1);
        check("ovs_ready", 32'(tx_ready), 32'd1);
        check("ovs_frames", perf_tx_frames, 32'd4);
        $display("oversize len=1519 count=%0d", perf_tx_oversize);

        fill(0, 0, 0); send(); wait_ready("zero");
        check_frame("zero", 1);
        check("zero_frames", perf_tx_frames, 32'd5);

        mark0 = cap.size();
        @(posedge clk); #1 tx_start = 1'b1;
        @(posedge clk); #1 tx_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tx_data = 8'(8'hF0 ^ i); tx_data_valid = 1'b1;
            @(posedge clk); #1;
        end
        tx_data_valid = 1'b0; tx_drop = 1'b1;
        @(posedge clk); #1 tx_drop = 1'b0;
        @(negedge clk);
        check("drop_count", perf_tx_dropped, 32'd1);
        check("drop_ready", 32'(tx_ready), 32'd1);
        fill(60, 8'h30, 7); send(); wait_ready("drop2");
        check_frame("drop2", 1);
        cnt = 0;
        for (int i = mark0; i < cap.size(); i++) if (cap[i][8]) cnt++;
        check("drop_only_second", cnt, 72);

        fill(100, 8'h11, 2); send();
        cnt = 0;
        for (int i = 0; i < 2000 && cnt < 38; i++) begin
            @(negedge clk);
            if (gmii_dvalid && gmii_en) cnt++;
        end
        check("rst_reach", cnt, 38);
        check("rst_byte30", 32'(gmii_data), 32'(exp_data[29]));
        check("rst_er", 32'(gmii_er), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_en", 32'(gmii_en), 32'd0);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        check("midrst_frames", perf_tx_frames, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        $display("reset during data byte 30 applied");
        repeat (3) @(posedge clk);
        fill(60, 8'h5A, 11); send(); wait_ready("post");
        check_frame("post", 1);
        check("post_frames", perf_tx_frames, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
